// File: rtl/speck64_ctrl.sv
// Iterative Speck64/128 block cipher controller: one round per cycle with on-the-fly key schedule.
// Optional decrypt support is compiled in with `define SPECK64_CTRL_DECRYPT_EN.
module speck64_ctrl #(
    parameter int unsigned ROUNDS = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [63:0]  in_text,
`ifdef SPECK64_CTRL_DECRYPT_EN
    input  logic         in_decrypt,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_text,
    output logic         busy
);

    localparam int unsigned CW = (ROUNDS > 1) ? $clog2(ROUNDS + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    function automatic logic [31:0] ror8(input logic [31:0] v);
        return {v[7:0], v[31:8]};
    endfunction

    function automatic logic [31:0] rol3(input logic [31:0] v);
        return {v[28:0], v[31:29]};
    endfunction

`ifdef SPECK64_CTRL_DECRYPT_EN
    function automatic logic [31:0] ror3(input logic [31:0] v);
        return {v[2:0], v[31:3]};
    endfunction

    function automatic logic [31:0] rol8(input logic [31:0] v);
        return {v[23:0], v[31:24]};
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
`ifdef SPECK64_CTRL_DECRYPT_EN
        , KEYGEN
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   x, y, k;
    logic [31:0]   l_a, l_b, l_c;
    logic [31:0]   l_new, k_next, run_x, run_y;

`ifdef SPECK64_CTRL_DECRYPT_EN
    logic          dec;
    logic [31:0]   kf [ROUNDS];
    logic [CW-1:0] kidx;
    logic [31:0]   dec_y;
`endif

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // l_a/l_b/l_c hold l[i], l[i+1], l[i+2] for the current round index i = cnt
    always_comb begin
        l_new  = (k + ror8(l_a)) ^ 32'(cnt);
        k_next = rol3(k) ^ l_new;
        run_x  = (ror8(x) + y) ^ k;
        run_y  = rol3(y) ^ run_x;
`ifdef SPECK64_CTRL_DECRYPT_EN
        kidx   = LAST - cnt;
        dec_y  = ror3(x ^ y);
        if (dec) begin
            run_y = dec_y;
            run_x = rol8((x ^ kf[kidx]) - dec_y);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            k         <= '0;
            l_a       <= '0;
            l_b       <= '0;
            l_c       <= '0;
            out_valid <= 1'b0;
            out_text  <= '0;
`ifdef SPECK64_CTRL_DECRYPT_EN
            dec       <= 1'b0;
            for (int unsigned i = 0; i < ROUNDS; i++) kf[i] <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x   <= in_text[63:32];
                        y   <= in_text[31:0];
                        k   <= in_key[31:0];
                        l_a <= in_key[63:32];
                        l_b <= in_key[95:64];
                        l_c <= in_key[127:96];
                        cnt <= '0;
`ifdef SPECK64_CTRL_DECRYPT_EN
                        dec   <= in_decrypt;
                        state <= in_decrypt ? KEYGEN : RUN;
`else
                        state <= RUN;
`endif
                    end
                end
`ifdef SPECK64_CTRL_DECRYPT_EN
                KEYGEN: begin
                    kf[cnt] <= k;
                    k       <= k_next;
                    l_a     <= l_b;
                    l_b     <= l_c;
                    l_c     <= l_new;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                RUN: begin
                    x   <= run_x;
                    y   <= run_y;
                    k   <= k_next;
                    l_a <= l_b;
                    l_b <= l_c;
                    l_c <= l_new;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_text  <= {run_x, run_y};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/speck64_ctrl.md
SPECK64_CTRL -- requirements
Module: speck64_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 27, meaning the number of Speck64/128 rounds per block.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning a request is presented.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept a request.
REQ-006 SHALL have port in_key, input, 128, meaning the key as {l2,l1,l0,k0}, each 32 bits, with k0 = [31:0].
REQ-007 SHALL have port in_text, input, 64, meaning the input block as {x,y}, with x = [63:32].
REQ-008 SHALL have port out_valid, output, 1, meaning out_text is a valid result.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-010 SHALL have port out_text, output, 64, meaning the result block as {x,y}.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, KEYGEN (decrypt builds only), RUN and DONE, with in_ready = 1 only in IDLE.
REQ-013 SHALL accept a request on the rising edge where in_valid and in_ready are both 1, latch in_key and in_text, clear the round counter to 0, and go to RUN; in_key and in_text are ignored at all other times.
REQ-014 SHALL, in RUN, apply one round per cycle using round key k[i], with i equal to the counter: x' = (ROR8(x) + y) ^ k[i]; y' = ROL3(y) ^ x'.
REQ-015 SHALL generate keys on the fly, one per cycle: l[i+3] = (k[i] + ROR8(l[i])) ^ i; k[i+1] = ROL3(k[i]) ^ l[i+3].
REQ-016 SHALL perform all additions and subtractions modulo 2^32, and SHALL XOR the round index i zero-extended to 32 bits.
REQ-017 SHALL, after the round with counter = ROUNDS-1, move to DONE and set out_valid = 1, exactly ROUNDS cycles after the accept edge; with the default of 27, that is 27 cycles.
REQ-018 SHALL hold out_text and out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge and clear out_valid.
REQ-019 SHALL, when in DONE with out_ready and in_valid both high, complete the output handshake only; the new request is accepted no earlier than the next cycle, in IDLE.
REQ-020 SHALL keep out_text at its last value while in IDLE and RUN, updating it only on entry to DONE.

Reset
REQ-021 SHALL, on rst = 1 regardless of clk, enter IDLE and set out_valid = 0, out_text = 0, busy = 0, the counter to 0, and all datapath and key registers to 0; in_ready = 1 once reset has been released.
REQ-022 SHALL, if reset is asserted mid-operation, abandon the block with no output produced, and after release SHALL accept a fresh request normally.

Configuration
REQ-023 SHALL, when the macro SPECK64_CTRL_DECRYPT_EN is defined, add input port in_decrypt (1 bit), latched at accept.
REQ-024 SHALL, with the macro defined and in_decrypt = 1, go to KEYGEN for ROUNDS cycles, storing k[0..ROUNDS-1] in a ROUNDS x 32 register file, and then go to RUN.
REQ-025 SHALL, in that decrypt RUN, apply inverse rounds with keys k[ROUNDS-1] down to k[0]: y' = ROR3(x ^ y); x' = ROL8((x ^ k) - y'); out_valid rises 2*ROUNDS cycles after accept.
REQ-026 SHALL, with the macro defined and in_decrypt = 0, behave exactly as in REQ-013 to REQ-020.
REQ-027 SHALL, without the macro, have no in_decrypt port, no KEYGEN state and no key register file, and SHALL be encrypt-only.

Verification
REQ-028 Bench SHALL cover: key 1b1a1918_13121110_0b0a0908_03020100, text 3b726574_7475432d -> out_text 8c6fa548_454e028b, with out_valid rising 27 cycles after accept.
REQ-029 Bench SHALL cover (macro defined): same key, text 8c6fa548_454e028b, in_decrypt = 1 -> out_text 3b726574_7475432d after 54 cycles.
REQ-030 Bench SHALL cover backpressure: out_ready held 0 for 10 cycles after out_valid -> out_text stable, in_ready = 0, and in_valid ignored; then out_ready = 1 -> IDLE next cycle.
REQ-031 Bench SHALL cover reset mid-block: rst pulsed at round 12 -> out_valid = 0 and out_text = 0 immediately; a subsequent REQ-028 request produces the correct result.
REQ-032 Bench SHALL cover back-to-back traffic: in_valid held 1 with out_ready = 1 for 3 blocks -> each block is accepted one cycle after its predecessor's output handshake, with correct results.
REQ-033 Bench SHALL cover input hold: in_text and in_key changed randomly during RUN -> the result still matches REQ-028.
